mem_arbiter: RTL and testbench

- Two-requester memory controller between the IFU (instruction fetch, read-only) and the LSU (loads/stores) and the single combinational DPI memory port.
- Serialises one transaction at a time and inserts a programmable access latency, modelling SRAM delay.
- Drives the memory's valid/wen/wmask/addr/wdata/rmask inputs and captures its rdata into a registered response.
- Returns the result to the granted requester over a valid/ready response handshake.

---
 rtl/mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (IFU fetch / LSU load-store) front end for a single
// combinational memory port. One transaction at a time: accept in IDLE, wait
// LATENCY cycles in ACCESS (strobing the memory in the last one), then hold the
// registered response in RESP until the owner takes it.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   ifu_req_valid/ready, ifu_raddr   fetch request (ready is combinational)
//   ifu_resp_valid/ready, ifu_rdata  fetch response
//   lsu_req_valid/ready, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask, lsu_rmask
//                                    load/store request (ready is combinational)
//   lsu_resp_valid/ready, lsu_rdata  load data / store completion
//   mem_valid, mem_wen, mem_wmask, mem_waddr, mem_wdata, mem_rmask, mem_raddr
//                                    memory port, non-zero only on the access cycle
//   mem_rdata                        combinational read data from memory
module mem_arbiter #(
  parameter int unsigned LATENCY = 1,
  parameter logic [2:0]  RMASK_W = 3'b010
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_raddr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [7:0]  lsu_wmask,
  input  logic [2:0]  lsu_rmask,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [31:0] lsu_rdata,
  output logic        mem_valid,
  output logic        mem_wen,
  output logic [7:0]  mem_wmask,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_rmask,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned MW    = 8;
  localparam int unsigned RW    = 3;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ACCESS = 2'b01;
  localparam logic [1:0] ST_RESP   = 2'b10;

  localparam logic GNT_IFU = 1'b0;
  localparam logic GNT_LSU = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef struct packed {
    logic          wen;
    logic [MW-1:0] wmask;
    logic [RW-1:0] rmask;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  req_t             req_q, req_d;
  logic [DW-1:0]    ifu_rdata_q, ifu_rdata_d;
  logic [DW-1:0]    lsu_rdata_q, lsu_rdata_d;

  logic idle_c;
  logic pick_lsu_c;
  logic mem_fire_c;
  logic resp_ready_c;

  // Arbitration: a lone requester wins; on a collision the one not granted last wins.
  assign idle_c        = (state_q == ST_IDLE);
  assign pick_lsu_c    = lsu_req_valid & (~ifu_req_valid | (last_q == GNT_IFU));
  assign lsu_req_ready = rst_n & idle_c & pick_lsu_c;
  assign ifu_req_ready = rst_n & idle_c & ifu_req_valid & ~pick_lsu_c;

  assign mem_fire_c   = (state_q == ST_ACCESS) && (cnt_q == '0);
  assign resp_ready_c = (owner_q == GNT_LSU) ? lsu_resp_ready : ifu_resp_ready;

  // Memory port is driven only on the single access cycle so a store lands once.
  assign mem_valid = mem_fire_c;
  assign mem_wen   = mem_fire_c & req_q.wen;
  assign mem_wmask = req_q.wmask & {MW{mem_fire_c}};
  assign mem_rmask = req_q.rmask & {RW{mem_fire_c}};
  assign mem_waddr = req_q.addr  & {AW{mem_fire_c}};
  assign mem_raddr = req_q.addr  & {AW{mem_fire_c}};
  assign mem_wdata = req_q.wdata & {DW{mem_fire_c}};

  assign ifu_resp_valid = (state_q == ST_RESP) && (owner_q == GNT_IFU);
  assign lsu_resp_valid = (state_q == ST_RESP) && (owner_q == GNT_LSU);
  assign ifu_rdata      = ifu_rdata_q;
  assign lsu_rdata      = lsu_rdata_q;

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    owner_d     = owner_q;
    req_d       = req_q;
    ifu_rdata_d = ifu_rdata_q;
    lsu_rdata_d = lsu_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (lsu_req_ready) begin
          req_d.wen   = lsu_wen;
          req_d.wmask = lsu_wmask;
          req_d.rmask = lsu_rmask;
          req_d.addr  = lsu_addr;
          req_d.wdata = lsu_wdata;
          owner_d     = GNT_LSU;
          last_d      = GNT_LSU;
          cnt_d       = CNT_LOAD;
          state_d     = ST_ACCESS;
        end else if (ifu_req_ready) begin
          req_d.wen   = 1'b0;
          req_d.wmask = '0;
          req_d.rmask = RMASK_W;
          req_d.addr  = ifu_raddr;
          req_d.wdata = '0;
          owner_d     = GNT_IFU;
          last_d      = GNT_IFU;
          cnt_d       = CNT_LOAD;
          state_d     = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (mem_fire_c) begin
          if (owner_q == GNT_LSU) begin
            lsu_rdata_d = req_q.wen ? '0 : mem_rdata;
          end else begin
            ifu_rdata_d = mem_rdata;
          end
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_q      <= GNT_IFU;
      owner_q     <= GNT_IFU;
      req_q       <= '0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      req_q       <= req_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a LATENCY=3 instance for most scenarios and a
// LATENCY=1 instance for the single-cycle fetch case. Inputs change just after
// the falling edge, outputs are sampled 1 ns later.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // LATENCY = 3 instance
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
  logic [31:0] ifu_raddr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  lsu_wmask;
  logic [2:0]  lsu_rmask;
  logic        mem_valid, mem_wen;
  logic [7:0]  mem_wmask;
  logic [31:0] mem_waddr, mem_wdata, mem_raddr, mem_rdata;
  logic [2:0]  mem_rmask;

  // LATENCY = 1 instance (IFU only)
  logic        d1_ifu_req_valid, d1_ifu_req_ready, d1_ifu_resp_valid, d1_ifu_resp_ready;
  logic [31:0] d1_ifu_raddr, d1_ifu_rdata;
  logic        d1_lsu_req_ready, d1_lsu_resp_valid;
  logic [31:0] d1_lsu_rdata;
  logic        d1_mem_valid, d1_mem_wen;
  logic [7:0]  d1_mem_wmask;
  logic [31:0] d1_mem_waddr, d1_mem_wdata, d1_mem_raddr, d1_mem_rdata;
  logic [2:0]  d1_mem_rmask;

  int n_cmp  = 0;
  int n_fail = 0;

  // Memory contents: ebreak at the reset vector, address-derived data elsewhere.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0010_0073;
    return a ^ 32'h5a5a_5a5a;
  endfunction

  assign mem_rdata    = mem_f(mem_raddr);
  assign d1_mem_rdata = mem_f(d1_mem_raddr);

  mem_arbiter #(.LATENCY(3), .RMASK_W(3'b010)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_raddr(ifu_raddr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_rmask(lsu_rmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
    .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_wmask(mem_wmask), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_rmask(mem_rmask), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.LATENCY(1), .RMASK_W(3'b010)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(d1_ifu_req_valid), .ifu_req_ready(d1_ifu_req_ready), .ifu_raddr(d1_ifu_raddr),
    .ifu_resp_valid(d1_ifu_resp_valid), .ifu_resp_ready(d1_ifu_resp_ready), .ifu_rdata(d1_ifu_rdata),
    .lsu_req_valid(1'b0), .lsu_req_ready(d1_lsu_req_ready), .lsu_wen(1'b0),
    .lsu_addr(32'h0), .lsu_wdata(32'h0), .lsu_wmask(8'h0), .lsu_rmask(3'b000),
    .lsu_resp_valid(d1_lsu_resp_valid), .lsu_resp_ready(1'b1), .lsu_rdata(d1_lsu_rdata),
    .mem_valid(d1_mem_valid), .mem_wen(d1_mem_wen), .mem_wmask(d1_mem_wmask), .mem_waddr(d1_mem_waddr),
    .mem_wdata(d1_mem_wdata), .mem_rmask(d1_mem_rmask), .mem_raddr(d1_mem_raddr), .mem_rdata(d1_mem_rdata)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    ifu_resp_ready = 1'b1;
    lsu_resp_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); #1;
    n_cmp++; if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", {ifu_req_ready, lsu_req_ready}); end
    n_cmp++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 00", {ifu_resp_valid, lsu_resp_valid}); end
    n_cmp++; if ({mem_valid, mem_wen, mem_wmask, mem_rmask, mem_waddr, mem_raddr, mem_wdata} !== '0) begin n_fail++; $display("FAIL reset_mem: valid=%b addr=%h expected all zero", mem_valid, mem_raddr); end
    n_cmp++; if ({ifu_rdata, lsu_rdata} !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h expected 0/0", ifu_rdata, lsu_rdata); end
    n_cmp++; if ({d1_ifu_req_ready, d1_ifu_resp_valid, d1_mem_valid, d1_ifu_rdata} !== 35'h0) begin n_fail++; $display("FAIL reset_dut1: got %b%b%b %h expected all zero", d1_ifu_req_ready, d1_ifu_resp_valid, d1_mem_valid, d1_ifu_rdata); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_ifu_fetch();
    step();
    d1_ifu_raddr = 32'h8000_0000;
    d1_ifu_req_valid = 1'b1;
    #1;
    n_cmp++; if (d1_ifu_req_ready !== 1'b1) begin n_fail++; $display("FAIL fetch_ready_T: got %b expected 1", d1_ifu_req_ready); end
    n_cmp++; if (d1_mem_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_mem_valid_T: got %b expected 0", d1_mem_valid); end
    step();
    d1_ifu_req_valid = 1'b0;
    #1;
    n_cmp++; if (d1_mem_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_mem_valid_T1: got %b expected 1", d1_mem_valid); end
    n_cmp++; if (d1_mem_rmask !== 3'b010) begin n_fail++; $display("FAIL fetch_rmask: got %b expected 010", d1_mem_rmask); end
    n_cmp++; if (d1_mem_raddr !== 32'h8000_0000) begin n_fail++; $display("FAIL fetch_raddr: got %h expected 80000000", d1_mem_raddr); end
    n_cmp++; if ({d1_mem_wen, d1_mem_wmask} !== 9'h0) begin n_fail++; $display("FAIL fetch_no_write: got %b/%h expected 0/00", d1_mem_wen, d1_mem_wmask); end
    step(); #1;
    n_cmp++; if (d1_mem_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_mem_valid_T2: got %b expected 0", d1_mem_valid); end
    n_cmp++; if (d1_ifu_resp_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_resp_valid_T2: got %b expected 1", d1_ifu_resp_valid); end
    n_cmp++; if (d1_ifu_rdata !== 32'h0010_0073) begin n_fail++; $display("FAIL fetch_rdata: got %h expected 00100073", d1_ifu_rdata); end
    step(); #1;
    n_cmp++; if (d1_ifu_resp_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_resp_done: got %b expected 0", d1_ifu_resp_valid); end
  endtask

  // Both requesters held high; collects three grants and expects LSU, IFU, LSU.
  task automatic test_collision();
    int g[3];
    int ng = 0;
    ifu_raddr = 32'h8000_0040;
    lsu_addr = 32'h8000_0080;
    lsu_wen = 1'b0;
    lsu_rmask = 3'b010;
    step();
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    for (int c = 0; c < 40 && ng < 3; c++) begin
      if (c != 0) step();
      #1;
      n_cmp++; if (ifu_req_ready && lsu_req_ready) begin n_fail++; $display("FAIL collide_both_ready: got 11 expected at most one"); end
      if (lsu_req_ready) begin g[ng] = 1; ng++; end
      else if (ifu_req_ready) begin g[ng] = 0; ng++; end
    end
    n_cmp++; if (ng !== 3) begin n_fail++; $display("FAIL collide_timeout: got %0d grants expected 3", ng); end
    if (ng == 3) begin
      n_cmp++; if ({g[0][0], g[1][0], g[2][0]} !== 3'b101) begin n_fail++; $display("FAIL collide_order: got %0d%0d%0d expected 101 (1=LSU)", g[0], g[1], g[2]); end
    end
    drain(6);
    n_cmp++; if (ifu_rdata !== mem_f(32'h8000_0040)) begin n_fail++; $display("FAIL collide_ifu_rdata: got %h expected %h", ifu_rdata, mem_f(32'h8000_0040)); end
    n_cmp++; if (lsu_rdata !== mem_f(32'h8000_0080)) begin n_fail++; $display("FAIL collide_lsu_rdata: got %h expected %h", lsu_rdata, mem_f(32'h8000_0080)); end
  endtask

  task automatic test_load();
    lsu_wen = 1'b0;
    lsu_addr = 32'h8000_0200;
    lsu_rmask = 3'b100;
    lsu_wmask = 8'h00;
    lsu_wdata = 32'h0;
    step();
    lsu_req_valid = 1'b1;
    #1;
    n_cmp++; if ({lsu_req_ready, ifu_req_ready} !== 2'b10) begin n_fail++; $display("FAIL load_ready: got %b expected 10", {lsu_req_ready, ifu_req_ready}); end
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i == 1) lsu_req_valid = 1'b0;
      #1;
      n_cmp++; if (mem_valid !== (i == 3)) begin n_fail++; $display("FAIL load_mem_valid_T%0d: got %b expected %b", i, mem_valid, (i == 3)); end
      if (i == 2) begin
        n_cmp++; if (mem_raddr !== 32'h0) begin n_fail++; $display("FAIL load_idle_raddr: got %h expected 0", mem_raddr); end
      end
      if (i == 3) begin
        n_cmp++; if ({mem_wen, mem_rmask, mem_raddr} !== {1'b0, 3'b100, 32'h8000_0200}) begin n_fail++; $display("FAIL load_mem_fields: got %b %b %h expected 0 100 80000200", mem_wen, mem_rmask, mem_raddr); end
      end
      if (i == 4) begin
        n_cmp++; if (lsu_resp_valid !== 1'b1) begin n_fail++; $display("FAIL load_resp_valid: got %b expected 1", lsu_resp_valid); end
        n_cmp++; if (lsu_rdata !== mem_f(32'h8000_0200)) begin n_fail++; $display("FAIL load_rdata: got %h expected %h", lsu_rdata, mem_f(32'h8000_0200)); end
      end
    end
    step(); #1;
    n_cmp++; if (lsu_resp_valid !== 1'b0) begin n_fail++; $display("FAIL load_resp_done: got %b expected 0", lsu_resp_valid); end
  endtask

  task automatic test_store();
    lsu_wen = 1'b1;
    lsu_addr = 32'h8000_0100;
    lsu_wdata = 32'hdead_beef;
    lsu_wmask = 8'h0f;
    lsu_rmask = 3'b000;
    lsu_req_valid = 1'b1;
    #1;
    n_cmp++; if (lsu_req_ready !== 1'b1) begin n_fail++; $display("FAIL store_ready: got %b expected 1", lsu_req_ready); end
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i == 1) lsu_req_valid = 1'b0;
      #1;
      n_cmp++; if ({mem_valid, mem_wen} !== ((i == 3) ? 2'b11 : 2'b00)) begin n_fail++; $display("FAIL store_strobe_T%0d: got %b expected %b", i, {mem_valid, mem_wen}, (i == 3) ? 2'b11 : 2'b00); end
      if (i == 3) begin
        n_cmp++; if ({mem_waddr, mem_wdata, mem_wmask} !== {32'h8000_0100, 32'hdead_beef, 8'h0f}) begin n_fail++; $display("FAIL store_fields: got %h %h %h expected 80000100 deadbeef 0f", mem_waddr, mem_wdata, mem_wmask); end
      end
      if (i == 4) begin
        n_cmp++; if (lsu_resp_valid !== 1'b1) begin n_fail++; $display("FAIL store_resp_valid: got %b expected 1", lsu_resp_valid); end
        n_cmp++; if (lsu_rdata !== 32'h0) begin n_fail++; $display("FAIL store_rdata: got %h expected 0", lsu_rdata); end
      end
    end
    lsu_wen = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_a;
    exp_a = mem_f(32'h8000_0300);
    lsu_wen = 1'b0;
    lsu_rmask = 3'b010;
    lsu_addr = 32'h8000_0300;
    lsu_resp_ready = 1'b0;
    lsu_req_valid = 1'b1;
    #1;
    n_cmp++; if (lsu_req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_first: got %b expected 1", lsu_req_ready); end
    step();
    lsu_addr = 32'h8000_0304;
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      step(); #1;
      n_cmp++; if ({lsu_resp_valid, lsu_req_ready} !== 2'b10) begin n_fail++; $display("FAIL bp_hold_%0d: got valid/ready %b expected 10", k, {lsu_resp_valid, lsu_req_ready}); end
      n_cmp++; if (lsu_rdata !== exp_a) begin n_fail++; $display("FAIL bp_rdata_%0d: got %h expected %h", k, lsu_rdata, exp_a); end
    end
    step();
    lsu_resp_ready = 1'b1;
    #1;
    n_cmp++; if ({lsu_resp_valid, lsu_req_ready} !== 2'b10) begin n_fail++; $display("FAIL bp_handshake: got valid/ready %b expected 10", {lsu_resp_valid, lsu_req_ready}); end
    step(); #1;
    n_cmp++; if ({lsu_resp_valid, lsu_req_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_next_accept: got valid/ready %b expected 01", {lsu_resp_valid, lsu_req_ready}); end
    n_cmp++; if (lsu_rdata !== exp_a) begin n_fail++; $display("FAIL bp_rdata_kept: got %h expected %h", lsu_rdata, exp_a); end
    step();
    lsu_req_valid = 1'b0;
    step();
    step();
    step(); #1;
    n_cmp++; if ({lsu_resp_valid, lsu_rdata} !== {1'b1, mem_f(32'h8000_0304)}) begin n_fail++; $display("FAIL bp_second: got %b %h expected 1 %h", lsu_resp_valid, lsu_rdata, mem_f(32'h8000_0304)); end
    step();
  endtask

  task automatic test_starvation();
    int ng = 0;
    int ifu_at = -1;
    ifu_raddr = 32'h8000_0000;
    lsu_addr = 32'h8000_0500;
    lsu_wen = 1'b0;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    for (int c = 0; c < 40 && ng < 2; c++) begin
      if (c != 0) step();
      #1;
      if (ifu_req_ready && ifu_at < 0) ifu_at = ng;
      if (ifu_req_ready || lsu_req_ready) ng++;
    end
    n_cmp++; if (!(ifu_at >= 0 && ifu_at < 2)) begin n_fail++; $display("FAIL starve_ifu_grant: got ifu grant index %0d expected 0 or 1", ifu_at); end
    drain(6);
    n_cmp++; if (ifu_rdata !== 32'h0010_0073) begin n_fail++; $display("FAIL starve_ifu_rdata: got %h expected 00100073", ifu_rdata); end
  endtask

  task automatic test_reset_mid();
    lsu_wen = 1'b1;
    lsu_addr = 32'h8000_0400;
    lsu_wdata = 32'h1122_3344;
    lsu_wmask = 8'hff;
    step();
    lsu_req_valid = 1'b1;
    #1;
    n_cmp++; if (lsu_req_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b expected 1", lsu_req_ready); end
    step();
    lsu_req_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({mem_valid, mem_wen, mem_wmask, mem_waddr, mem_wdata} !== '0) begin n_fail++; $display("FAIL rmid_mem_zero: valid=%b waddr=%h expected zero", mem_valid, mem_waddr); end
    n_cmp++; if ({lsu_resp_valid, ifu_resp_valid, lsu_req_ready, ifu_req_ready} !== 4'b0) begin n_fail++; $display("FAIL rmid_ctrl_zero: got %b expected 0000", {lsu_resp_valid, ifu_resp_valid, lsu_req_ready, ifu_req_ready}); end
    n_cmp++; if ({lsu_rdata, ifu_rdata} !== 64'h0) begin n_fail++; $display("FAIL rmid_rdata_zero: got %h/%h expected 0/0", lsu_rdata, ifu_rdata); end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(); #1;
      n_cmp++; if ({mem_valid, lsu_resp_valid, ifu_resp_valid} !== 3'b000) begin n_fail++; $display("FAIL rmid_after_%0d: got %b expected 000", i, {mem_valid, lsu_resp_valid, ifu_resp_valid}); end
    end
    // last_grant must be back to IFU, so the LSU wins a fresh collision.
    lsu_wen = 1'b0;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    #1;
    n_cmp++; if ({lsu_req_ready, ifu_req_ready} !== 2'b10) begin n_fail++; $display("FAIL rmid_last_grant: got lsu/ifu ready %b expected 10", {lsu_req_ready, ifu_req_ready}); end
    step();
    drain(6);
  endtask

  initial begin
    rst_n = 1'b0;
    ifu_req_valid = 1'b0; ifu_raddr = 32'h0; ifu_resp_ready = 1'b1;
    lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = 32'h0; lsu_wdata = 32'h0;
    lsu_wmask = 8'h0; lsu_rmask = 3'b0; lsu_resp_ready = 1'b1;
    d1_ifu_req_valid = 1'b0; d1_ifu_raddr = 32'h0; d1_ifu_resp_ready = 1'b1;
    test_reset();
    test_collision();
    test_ifu_fetch();
    test_load();
    test_store();
    test_backpressure();
    test_starvation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
